lock_in_detector: RTL and testbench
===================================

LOCK_IN_DETECTOR -- requirements
Module: lock_in_detector

Interface
REQ-001 SHALL have parameter N_LOG2, default 8, meaning log2 of the number of samples per integration block.
REQ-002 SHALL have port clk  input  1  system clock; all logic is rising-edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port enable  input  1  high to run integration; low to abort and idle.
REQ-005 SHALL have port phase_inc  input  8  reference phase step per accepted sample; captured on the enable rise.
REQ-006 SHALL have port phase_offset  input  8  reference start phase; captured on the enable rise.
REQ-007 SHALL have port sample_valid  input  1  sample qualifier.
REQ-008 SHALL have port sample  input  8  signed two's-complement input sample.
REQ-009 SHALL have port i_out  output  N_LOG2+16  signed in-phase sum of sample*cos.
REQ-010 SHALL have port q_out  output  N_LOG2+16  signed quadrature sum of sample*sin.
REQ-011 SHALL have port out_valid  output  1  one-cycle pulse marking new i_out/q_out.
REQ-012 SHALL have port busy  output  1  high while in RUN.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and RUN.
REQ-014 SHALL transition IDLE->RUN on the first edge with enable=1, loading phase<=phase_offset, inc<=phase_inc, count<=0, accumulators<=0.
REQ-015 SHALL transition RUN->IDLE on any edge with enable=0, clearing count and accumulators, squashing in-flight pipeline data, and suppressing out_valid.
REQ-016 SHALL accept a sample only when state=RUN and sample_valid=1; no other input samples are accepted.
REQ-017 SHALL advance the 8-bit phase by inc modulo 256 per accepted sample, and not otherwise.
REQ-018 SHALL use a sine table sin(k)=round(127*sin(2*pi*k/256)), k=0..255, with cos(k)=sin((k+64) mod 256); all entries lie in -127..127.
REQ-019 SHALL register sample*cos(phase) and sample*sin(phase) as 16-bit signed products on the edge that accepts the sample (stage 1).
REQ-020 SHALL add the stage-1 products into N_LOG2+16-bit signed accumulators on the next edge (stage 2); no saturation is required, since |sum| <= 2^N_LOG2*16256 always fits.
REQ-021 SHALL count accepted samples modulo 2^N_LOG2; the accepted sample with count=2^N_LOG2-1 closes the block.
REQ-022 SHALL, at stage 2 of the closing sample, load i_out/q_out with the full block sum, pulse out_valid for exactly one cycle, and restart the accumulators from zero in the same edge; latency is 2 edges from acceptance to out_valid.
REQ-023 SHALL treat the accepted sample that follows a closing sample as the first sample of the next block without a bubble, with the phase continuing and not reloading.
REQ-024 SHALL produce results that do not depend on gaps in sample_valid.
REQ-025 SHALL hold i_out/q_out between pulses.
REQ-026 SHALL assert busy combinationally equal to (state==RUN).

Reset
REQ-027 SHALL, on reset_n low, asynchronously force state=IDLE, phase=0, inc=0, count=0, accumulators=0, pipeline valid=0, i_out=0, q_out=0, out_valid=0.
REQ-028 SHALL resume operation at the first rising clk edge after reset_n deasserts, under normal enable rules.
REQ-029 SHALL, if reset occurs mid-block, discard the partial block and emit no out_valid.

Verification
REQ-030 SHALL verify reset: assert reset_n=0 mid-RUN -> all outputs 0 immediately, no out_valid after release until a new full block.
REQ-031 SHALL verify DC rejection: phase_inc=8, phase_offset=0, sample=100 for 256 valid cycles -> one out_valid, i_out=0, q_out=0.
REQ-032 SHALL verify full scale: phase_inc=0, phase_offset=64, sample=-128 x256 -> i_out=0, q_out=-4161536, out_valid 2 edges after the last acceptance.
REQ-033 SHALL verify coherent input: phase_inc=8, phase_offset=0, sample=cos(8n) -> q_out=0 exactly, and i_out matches the golden model (positive, about 2.06e6).
REQ-034 SHALL verify abort: enable drops after 100 accepted samples, then re-rises -> no out_valid until 256 further acceptances, with the result equal to a clean run.
REQ-035 SHALL verify gaps and back-to-back blocks: random sample_valid gaps plus 512 samples -> two out_valid pulses with results identical to contiguous stimulus, and no lost sample at the block boundary.

Source files
------------

// File: rtl/lock_in_detector.sv
// Lock-in detector: mixes each sample with an NCO cos/sin and integrates I/Q over 2^N_LOG2 samples.
// Latency: out_valid and the block sums appear 2 edges after the block-closing sample is accepted.
// Backpressure: none; every sample_valid beat in RUN is taken, and gaps only stall the NCO and counter.
module lock_in_detector #(
    parameter int N_LOG2 = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [7:0]                phase_inc,
    input  logic [7:0]                phase_offset,
    input  logic                      sample_valid,
    input  logic signed [7:0]         sample,
    output logic signed [N_LOG2+15:0] i_out,
    output logic signed [N_LOG2+15:0] q_out,
    output logic                      out_valid,
    output logic                      busy
);
    localparam int AW = N_LOG2 + 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state;
    logic [7:0]           phase;
    logic [7:0]           inc;
    logic [N_LOG2-1:0]    count;
    logic signed [15:0]   prod_i;
    logic signed [15:0]   prod_q;
    logic                 s1_vld;
    logic                 s1_last;
    logic signed [AW-1:0] acc_i;
    logic signed [AW-1:0] acc_q;

    logic signed [7:0]    cos_val;
    logic signed [7:0]    sin_val;
    logic signed [15:0]   mul_i;
    logic signed [15:0]   mul_q;
    logic signed [AW-1:0] sum_i;
    logic signed [AW-1:0] sum_q;

    // First quadrant of round(127*sin(2*pi*m/256)), m = 0..64.
    function automatic logic [6:0] quarter_lut(input logic [6:0] m);
        logic [6:0] q;
        case (m)
            7'd0:  q = 7'd0;
            7'd1:  q = 7'd3;
            7'd2:  q = 7'd6;
            7'd3:  q = 7'd9;
            7'd4:  q = 7'd12;
            7'd5:  q = 7'd16;
            7'd6:  q = 7'd19;
            7'd7:  q = 7'd22;
            7'd8:  q = 7'd25;
            7'd9:  q = 7'd28;
            7'd10: q = 7'd31;
            7'd11: q = 7'd34;
            7'd12: q = 7'd37;
            7'd13: q = 7'd40;
            7'd14: q = 7'd43;
            7'd15: q = 7'd46;
            7'd16: q = 7'd49;
            7'd17: q = 7'd51;
            7'd18: q = 7'd54;
            7'd19: q = 7'd57;
            7'd20: q = 7'd60;
            7'd21: q = 7'd63;
            7'd22: q = 7'd65;
            7'd23: q = 7'd68;
            7'd24: q = 7'd71;
            7'd25: q = 7'd73;
            7'd26: q = 7'd76;
            7'd27: q = 7'd78;
            7'd28: q = 7'd81;
            7'd29: q = 7'd83;
            7'd30: q = 7'd85;
            7'd31: q = 7'd88;
            7'd32: q = 7'd90;
            7'd33: q = 7'd92;
            7'd34: q = 7'd94;
            7'd35: q = 7'd96;
            7'd36: q = 7'd98;
            7'd37: q = 7'd100;
            7'd38: q = 7'd102;
            7'd39: q = 7'd104;
            7'd40: q = 7'd106;
            7'd41: q = 7'd107;
            7'd42: q = 7'd109;
            7'd43: q = 7'd111;
            7'd44: q = 7'd112;
            7'd45: q = 7'd113;
            7'd46: q = 7'd115;
            7'd47: q = 7'd116;
            7'd48: q = 7'd117;
            7'd49: q = 7'd118;
            7'd50: q = 7'd120;
            7'd51: q = 7'd121;
            7'd52: q = 7'd122;
            7'd53: q = 7'd122;
            7'd54: q = 7'd123;
            7'd55: q = 7'd124;
            7'd56: q = 7'd125;
            7'd57: q = 7'd125;
            7'd58: q = 7'd126;
            7'd59: q = 7'd126;
            7'd60: q = 7'd126;
            7'd61: q = 7'd127;
            7'd62: q = 7'd127;
            7'd63: q = 7'd127;
            7'd64: q = 7'd127;
            default: q = 7'd0;
        endcase
        return q;
    endfunction

    // Second quadrant mirrors the first; the lower half-circle is the negated upper half.
    function automatic logic signed [7:0] sin_lut(input logic [7:0] k);
        logic [6:0] m;
        logic [6:0] mag;
        m   = k[6] ? (7'd64 - {1'b0, k[5:0]}) : {1'b0, k[5:0]};
        mag = quarter_lut(m);
        return k[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    always_comb begin
        sin_val = sin_lut(phase);
        cos_val = sin_lut(phase + 8'd64);
        mul_i   = 16'(sample) * 16'(cos_val);
        mul_q   = 16'(sample) * 16'(sin_val);
        sum_i   = acc_i + AW'(prod_i);
        sum_q   = acc_q + AW'(prod_q);
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            phase     <= '0;
            inc       <= '0;
            count     <= '0;
            prod_i    <= '0;
            prod_q    <= '0;
            s1_vld    <= 1'b0;
            s1_last   <= 1'b0;
            acc_i     <= '0;
            acc_q     <= '0;
            i_out     <= '0;
            q_out     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state  <= RUN;
                        phase  <= phase_offset;
                        inc    <= phase_inc;
                        count  <= '0;
                        acc_i  <= '0;
                        acc_q  <= '0;
                        s1_vld <= 1'b0;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        // Abort: the partial block and any product still in stage 1 are dropped.
                        state  <= IDLE;
                        count  <= '0;
                        acc_i  <= '0;
                        acc_q  <= '0;
                        s1_vld <= 1'b0;
                    end else begin
                        s1_vld <= sample_valid;
                        if (sample_valid) begin
                            prod_i  <= mul_i;
                            prod_q  <= mul_q;
                            s1_last <= (count == '1);
                            count   <= count + N_LOG2'(1);
                            phase   <= phase + inc;
                        end
                        if (s1_vld) begin
                            if (s1_last) begin
                                // Publish the closed block and start the next one from zero.
                                i_out     <= sum_i;
                                q_out     <= sum_q;
                                out_valid <= 1'b1;
                                acc_i     <= '0;
                                acc_q     <= '0;
                            end else begin
                                acc_i <= sum_i;
                                acc_q <= sum_q;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lock_in_detector.sv
// Bench for lock_in_detector: directed vector table, multi-cycle corner sequences and a random soak,
// all checked against a per-sample arithmetic reference (phase = offset + n*inc, block sums of sample*cos/sin).
module tb_lock_in_detector;
    localparam int NL  = 8;
    localparam int BLK = 1 << NL;
    localparam int W   = NL + 16;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                enable = 1'b0;
    logic [7:0]          phase_inc = '0;
    logic [7:0]          phase_offset = '0;
    logic                sample_valid = 1'b0;
    logic signed [7:0]   sample = '0;
    logic signed [W-1:0] i_out;
    logic signed [W-1:0] q_out;
    logic                out_valid;
    logic                busy;

    int checks = 0;
    int errors = 0;
    int sin_tab[256];

    bit     m_run = 0;
    int     m_off, m_inc, m_n;
    longint m_si, m_sq;
    bit     pend = 0;
    longint pend_i, pend_q;
    bit     exp_vld = 0;
    longint hold_i = 0, hold_q = 0;
    int     pulses = 0;
    longint got_i[$];
    longint got_q[$];
    int     stim[$];

    typedef struct {
        logic [7:0] pinc;
        logic [7:0] poff;
        int         smp;
        longint     ei;
        longint     eq;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    lock_in_detector #(.N_LOG2(NL)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .phase_inc    (phase_inc),
        .phase_offset (phase_offset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .i_out        (i_out),
        .q_out        (q_out),
        .out_valid    (out_valid),
        .busy         (busy)
    );

    function automatic int cosv(int k);
        return sin_tab[(k + 64) % 256];
    endfunction

    function automatic longint ref_sum(bit quad, int off, int inc, int first, int cnt);
        longint acc = 0;
        for (int n = first; n < first + cnt; n++) begin
            int ph = (off + n * inc) % 256;
            acc += longint'(stim[n]) * (quad ? sin_tab[ph] : cosv(ph));
        end
        return acc;
    endfunction

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour for one rising edge, evaluated with the inputs that edge saw.
    task automatic model_edge();
        int s;
        int ph;
        exp_vld = 0;
        if (!m_run) begin
            if (enable) begin
                m_run = 1; m_off = int'(phase_offset); m_inc = int'(phase_inc);
                m_n = 0; m_si = 0; m_sq = 0; pend = 0;
            end
        end else if (!enable) begin
            m_run = 0; pend = 0;
        end else begin
            if (pend) begin
                exp_vld = 1; hold_i = pend_i; hold_q = pend_q; pend = 0;
            end
            if (sample_valid) begin
                s  = int'(sample);
                ph = (m_off + m_n * m_inc) % 256;
                m_si += longint'(s * cosv(ph));
                m_sq += longint'(s * sin_tab[ph]);
                m_n++;
                if (m_n % BLK == 0) begin
                    pend = 1; pend_i = m_si; pend_q = m_sq; m_si = 0; m_sq = 0;
                end
            end
        end
    endtask

    task automatic compare();
        check("out_valid", out_valid, exp_vld);
        check("busy", busy, m_run);
        check("i_out", i_out, hold_i);
        check("q_out", q_out, hold_q);
        if (out_valid) begin
            pulses++;
            got_i.push_back(longint'(i_out));
            got_q.push_back(longint'(q_out));
        end
    endtask

    task automatic cyc(input bit en, input bit sv, input int s);
        enable = en; sample_valid = sv; sample = 8'(s);
        @(posedge clk);
        model_edge();
        #1;
        compare();
        @(negedge clk);
    endtask

    task automatic run_const(input logic [7:0] pinc, input logic [7:0] poff, input int smp);
        phase_inc = pinc; phase_offset = poff;
        cyc(1, 0, 0);
        for (int n = 0; n < BLK; n++) cyc(1, 1, smp);
        cyc(1, 0, 0);
    endtask

    initial begin
        int p0;
        int off_r, inc_r;
        for (int k = 0; k < 256; k++) begin
            real v;
            v = 127.0 * $sin(2.0 * 3.141592653589793 * k / 256.0);
            sin_tab[k] = (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
        end

        vecs[0] = '{8'd8,   8'd0,   100,  0,        0};
        vecs[1] = '{8'd0,   8'd64,  -128, 0,        -4161536};
        vecs[2] = '{8'd0,   8'd0,   50,   1625600,  0};
        vecs[3] = '{8'd0,   8'd128, 1,    -32512,   0};
        vecs[4] = '{8'd0,   8'd32,  10,   230400,   230400};
        vecs[5] = '{8'd128, 8'd0,   127,  0,        0};
        vecs[6] = '{8'd0,   8'd0,   -128, -4161536, 0};
        vecs[7] = '{8'd0,   8'd192, 127,  0,        -4129024};

        repeat (2) @(negedge clk);
        check("rst_i", i_out, 0);
        check("rst_q", q_out, 0);
        check("rst_vld", out_valid, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        cyc(0, 1, 5);
        cyc(0, 0, 0);

        for (int v = 0; v < 8; v++) begin
            p0 = pulses;
            run_const(vecs[v].pinc, vecs[v].poff, vecs[v].smp);
            check("tbl_pulses", pulses - p0, 1);
            check("tbl_i", got_i[$], vecs[v].ei);
            check("tbl_q", got_q[$], vecs[v].eq);
            cyc(0, 0, 0);
        end

        // Coherent reference: sample tracks cos of the NCO phase.
        phase_inc = 8'd8; phase_offset = 8'd0;
        p0 = pulses;
        cyc(1, 0, 0);
        for (int n = 0; n < BLK; n++) cyc(1, 1, sin_tab[(8 * n + 64) % 256]);
        cyc(1, 0, 0);
        check("coh_pulses", pulses - p0, 1);
        check("coh_q", got_q[$], 0);
        check("coh_i_range", (got_i[$] > 2000000 && got_i[$] < 2100000), 1);

        // Asynchronous reset mid-block.
        phase_inc = 8'd3; phase_offset = 8'd5;
        cyc(1, 0, 0);
        for (int n = 0; n < 60; n++) cyc(1, 1, int'($urandom_range(0, 255)) - 128);
        #2 reset_n = 1'b0;
        #1;
        check("arst_i", i_out, 0);
        check("arst_q", q_out, 0);
        check("arst_vld", out_valid, 0);
        check("arst_busy", busy, 0);
        m_run = 0; pend = 0; hold_i = 0; hold_q = 0;
        @(negedge clk);
        reset_n = 1'b1;
        p0 = pulses;
        cyc(1, 0, 0);
        for (int n = 0; n < BLK - 1; n++) cyc(1, 1, int'($urandom_range(0, 255)) - 128);
        check("arst_no_early", pulses - p0, 0);
        cyc(1, 1, 77);
        cyc(1, 0, 0);
        check("arst_block", pulses - p0, 1);
        cyc(0, 0, 0);

        // Abort after 100 samples, then a clean block.
        phase_inc = 8'd11; phase_offset = 8'd200;
        cyc(1, 0, 0);
        for (int n = 0; n < 100; n++) cyc(1, 1, int'($urandom_range(0, 255)) - 128);
        repeat (3) cyc(0, 1, 9);
        off_r = 17; inc_r = 5;
        phase_inc = 8'(inc_r); phase_offset = 8'(off_r);
        stim.delete();
        for (int n = 0; n < BLK; n++) stim.push_back(int'($urandom_range(0, 255)) - 128);
        p0 = pulses;
        cyc(1, 0, 0);
        for (int n = 0; n < BLK; n++) cyc(1, 1, stim[n]);
        cyc(1, 0, 0);
        check("abort_pulses", pulses - p0, 1);
        check("abort_i", got_i[$], ref_sum(0, off_r, inc_r, 0, BLK));
        check("abort_q", got_q[$], ref_sum(1, off_r, inc_r, 0, BLK));
        cyc(0, 0, 0);

        // Two back-to-back blocks with random valid gaps, contiguous around the boundary.
        off_r = int'($urandom_range(0, 255)); inc_r = int'($urandom_range(1, 255));
        phase_inc = 8'(inc_r); phase_offset = 8'(off_r);
        stim.delete();
        for (int n = 0; n < 2 * BLK; n++) stim.push_back(int'($urandom_range(0, 255)) - 128);
        p0 = pulses;
        cyc(1, 0, 0);
        for (int n = 0; n < 2 * BLK; n++) begin
            if (n < BLK - 6 || n > BLK + 4)
                for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++)
                    cyc(1, 0, int'($urandom_range(0, 255)) - 128);
            cyc(1, 1, stim[n]);
        end
        cyc(1, 0, 0);
        check("gap_pulses", pulses - p0, 2);
        if (pulses - p0 == 2) begin
            check("gap_i0", got_i[$-1], ref_sum(0, off_r, inc_r, 0, BLK));
            check("gap_q0", got_q[$-1], ref_sum(1, off_r, inc_r, 0, BLK));
            check("gap_i1", got_i[$], ref_sum(0, off_r, inc_r, BLK, BLK));
            check("gap_q1", got_q[$], ref_sum(1, off_r, inc_r, BLK, BLK));
        end

        // Random soak: rare enable drops, random valids, samples and NCO settings.
        for (int c = 0; c < 3000; c++) begin
            phase_inc    = 8'($urandom_range(0, 255));
            phase_offset = 8'($urandom_range(0, 255));
            cyc($urandom_range(0, 999) != 0, $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 255)) - 128);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
